// File: rtl/sva_result_arb.sv
// Round-robin arbiter collecting per-checker assertion results into one output stream.
// Optional result counters are compiled in with `define SVA_RESULT_CNT_EN.
module sva_result_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TS_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                       gclk,
    input  logic                       grst,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [2*NUM_REQ-1:0]       req_code,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic [1:0]                 out_code,
    output logic [TS_WIDTH-1:0]        out_ts,
    output logic                       ovf
`ifdef SVA_RESULT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]       pass_cnt,
    output logic [CNT_WIDTH-1:0]       fail_cnt,
    output logic [CNT_WIDTH-1:0]       lazy_cnt
`endif
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    out_state_t            r_state;
    out_state_t            w_state_nxt;

    logic [TS_WIDTH-1:0]   r_ts;
    logic [NUM_REQ-1:0]    r_slot_vld;
    logic [1:0]            r_slot_code [NUM_REQ];
    logic [TS_WIDTH-1:0]   r_slot_ts   [NUM_REQ];
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_out_id;
    logic [1:0]            r_out_code;
    logic [TS_WIDTH-1:0]   r_out_ts;
    logic                  r_ovf;

    logic                  w_pend;
    logic                  w_load;
    logic                  w_gnt;
    logic [IDW-1:0]        w_gnt_idx;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [NUM_REQ-1:0]    w_code_nz;
    logic [NUM_REQ-1:0]    w_rdy;
    logic [NUM_REQ-1:0]    w_take;
    logic                  w_ovf_hit;

    // (ptr + k) mod NUM_REQ, one bit wider so non-power-of-two sizes wrap correctly
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int unsigned k);
        logic [IDW:0] sum;
        sum = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NUM_REQ))
            sum = sum - (IDW+1)'(NUM_REQ);
        return sum[IDW-1:0];
    endfunction

    always_comb begin
        w_pend    = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_pend && r_slot_vld[rr_idx(r_rr_ptr, k)]) begin
                w_pend    = 1'b1;
                w_gnt_idx = rr_idx(r_rr_ptr, k);
            end
        end

        w_load   = (r_state == ST_EMPTY) || out_rdy;
        w_gnt    = w_pend && w_load;
        w_gnt_oh = '0;
        if (w_gnt)
            w_gnt_oh[w_gnt_idx] = 1'b1;

        for (int unsigned i = 0; i < NUM_REQ; i++)
            w_code_nz[i] = |req_code[2*i +: 2];

        // a slot being granted this cycle can be refilled in the same cycle
        w_rdy     = ~r_slot_vld | w_gnt_oh | {NUM_REQ{grst}};
        w_take    = req_vld & w_rdy & w_code_nz;
        w_ovf_hit = |(req_vld & w_code_nz & ~w_rdy);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_pend) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (out_rdy && !w_pend) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_ts       <= '0;
            r_slot_vld <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_slot_code[i] <= '0;
                r_slot_ts[i]   <= '0;
            end
            r_rr_ptr   <= '0;
            r_out_id   <= '0;
            r_out_code <= '0;
            r_out_ts   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_ovf_hit)
                r_ovf <= 1'b1;
            if (w_gnt) begin
                r_out_id   <= w_gnt_idx;
                r_out_code <= r_slot_code[w_gnt_idx];
                r_out_ts   <= r_slot_ts[w_gnt_idx];
                r_rr_ptr   <= rr_idx(w_gnt_idx, 1);
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_take[i]) begin
                    r_slot_vld[i]  <= 1'b1;
                    r_slot_code[i] <= req_code[2*i +: 2];
                    r_slot_ts[i]   <= r_ts;
                end else if (w_gnt_oh[i]) begin
                    r_slot_vld[i]  <= 1'b0;
                end
            end
        end
    end

    assign req_rdy  = w_rdy;
    assign out_vld  = (r_state == ST_HOLD);
    assign out_id   = r_out_id;
    assign out_code = r_out_code;
    assign out_ts   = r_out_ts;
    assign ovf      = r_ovf;

`ifdef SVA_RESULT_CNT_EN
    logic [CNT_WIDTH-1:0] r_pass_cnt;
    logic [CNT_WIDTH-1:0] r_fail_cnt;
    logic [CNT_WIDTH-1:0] r_lazy_cnt;
    logic                 w_fire;

    assign w_fire = out_vld && out_rdy;

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_lazy_cnt <= '0;
        end else if (w_fire) begin
            if (r_out_code == 2'b01 && r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
            if (r_out_code == 2'b10 && r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
            if (r_out_code == 2'b11 && r_lazy_cnt != '1) r_lazy_cnt <= r_lazy_cnt + 1'b1;
        end
    end

    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;
    assign lazy_cnt = r_lazy_cnt;
`endif

endmodule
